// File: rtl/hall_emu.sv
// Rotor and hall-sensor emulator: integrates gate-drive torque into velocity and
// position and steps a registered three-phase hall sequence on position carry.
module hall_emu #(
  parameter int         VEL_W       = 16,
  parameter int         POS_W       = 20,
  parameter int         TORQUE      = 4,
  parameter int         FRIC_SHIFT  = 8,
  parameter int         BRAKE_SHIFT = 4,
  parameter logic [2:0] INIT_HALL   = 3'b101
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             highGrn,
  input  logic             lowGrn,
  input  logic             highYlw,
  input  logic             lowYlw,
  input  logic             highBlu,
  input  logic             lowBlu,
  output logic             hallGrn,
  output logic             hallYlw,
  output logic             hallBlu,
  output logic [VEL_W-1:0] vel,
  output logic             shoot_thru
);

  localparam int SW = VEL_W + 2;

  // One position carry must never skip more than one hall step.
  if (VEL_W >= POS_W) begin : g_width_check
    $error("hall_emu: VEL_W must be smaller than POS_W");
  end

  // Encodings equal the {Grn,Ylw,Blu} hall code so outputs are the state bits.
  typedef enum logic [2:0] {
    H101 = 3'b101,
    H100 = 3'b100,
    H110 = 3'b110,
    H010 = 3'b010,
    H011 = 3'b011,
    H001 = 3'b001
  } hall_e;

  typedef enum logic [2:0] {
    DRV_COAST,
    DRV_FWD,
    DRV_REV,
    DRV_BRAKE,
    DRV_SHOOT
  } drive_e;

  // Phase masks, bit 0 = green, bit 1 = yellow, bit 2 = blue.
  localparam logic [2:0] M_GRN = 3'b001;
  localparam logic [2:0] M_YLW = 3'b010;
  localparam logic [2:0] M_BLU = 3'b100;

  hall_e              state;
  hall_e              state_next;
  hall_e              step_next;
  drive_e             drive;
  logic [2:0]         hi;
  logic [2:0]         lo;
  logic [2:0]         src_m;
  logic [2:0]         snk_m;
  logic [VEL_W-1:0]   fric;
  logic [VEL_W-1:0]   extra;
  logic [VEL_W-1:0]   vel_next;
  logic signed [SW-1:0] delta;
  logic signed [SW-1:0] vel_sum;
  logic [POS_W-1:0]   pos;
  logic [POS_W:0]     pos_sum;
  logic               carry;

  assign hi = {highBlu, highYlw, highGrn};
  assign lo = {lowBlu, lowYlw, lowGrn};

  assign {hallGrn, hallYlw, hallBlu} = state;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    src_m     = M_GRN;
    snk_m     = M_YLW;
    step_next = hall_e'(INIT_HALL);
    case (state)
      H101: begin src_m = M_GRN; snk_m = M_YLW; step_next = H100; end
      H100: begin src_m = M_GRN; snk_m = M_BLU; step_next = H110; end
      H110: begin src_m = M_YLW; snk_m = M_BLU; step_next = H010; end
      H010: begin src_m = M_YLW; snk_m = M_GRN; step_next = H011; end
      H011: begin src_m = M_BLU; snk_m = M_GRN; step_next = H001; end
      H001: begin src_m = M_BLU; snk_m = M_YLW; step_next = H101; end
      default: begin
        src_m     = M_GRN;
        snk_m     = M_YLW;
        step_next = hall_e'(INIT_HALL);
      end
    endcase
  end

  always_comb begin
    drive = DRV_COAST;
    if (|(hi & lo)) begin
      drive = DRV_SHOOT;
    end else if (|(hi & src_m) && |(lo & snk_m)) begin
      drive = DRV_FWD;
    end else if (|(lo & src_m) && |(hi & snk_m)) begin
      drive = DRV_REV;
    end else if ((&lo) && !(|hi)) begin
      drive = DRV_BRAKE;
    end
  end

  always_comb begin
    delta = '0;
    extra = '0;
    fric  = vel >> FRIC_SHIFT;
    if (fric == '0 && vel != '0) fric = VEL_W'(1);
    case (drive)
      DRV_FWD:   delta = SW'(TORQUE);
      DRV_REV:   delta = -SW'(TORQUE);
      DRV_BRAKE: extra = vel >> BRAKE_SHIFT;
      default:   ;
    endcase

    vel_sum = $signed({2'b00, vel}) + delta
            - $signed({2'b00, fric}) - $signed({2'b00, extra});
    // Clamp to [0, 2^VEL_W-1]: sign bit means underflow, next bit overflow.
    if (vel_sum[SW-1])      vel_next = '0;
    else if (vel_sum[SW-2]) vel_next = '1;
    else                    vel_next = vel_sum[VEL_W-1:0];

    pos_sum    = {1'b0, pos} + (POS_W+1)'(vel);
    carry      = pos_sum[POS_W];
    state_next = carry ? step_next : state;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= hall_e'(INIT_HALL);
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the sticky fault sits on the async reset too, so only rst_n can clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vel        <= '0;
      pos        <= '0;
      shoot_thru <= 1'b0;
    end else begin
      vel <= vel_next;
      pos <= pos_sum[POS_W-1:0];
      if (drive == DRV_SHOOT) shoot_thru <= 1'b1;
    end
  end

endmodule
